fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the DLX pipeline. It owns the PC and drives the instruction-memory request handshake. It presents the fetched word and its PC+4 to the decode/control stage, honours that stage's `stall`, and resolves its `beqz`/`bnez`/`jump`/`jumpReg` outputs into a PC redirect with a one-instruction squash. There are no branch delay slots.

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: DLX instruction fetch and IF/ID pipeline register with a
// one-entry skid buffer, branch/jump redirect and one-instruction squash.
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0015
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        beqz,
    input  logic        bnez,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        rs1_zero,
    input  logic [15:0] imm16,
    input  logic [25:0] value,
    input  logic [31:0] reg_target,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic        redirect
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] pend_pc, pend_pc_next;
    logic [31:0] skid_instr, skid_instr_next;
    logic [31:0] skid_pc4, skid_pc4_next;
    logic [31:0] if_instr_next, if_pc4_next;
    logic        if_valid_next;
    logic        ack, take;
    logic [31:0] pc_plus4, target_raw, target;

    // Gating with rst_n makes the request drop the instant reset asserts.
    assign imem_req  = rst_n & (state != HOLD);
    assign imem_addr = pc;
    assign ack       = imem_req & imem_ack;
    assign pc_plus4  = pc + 32'd4;

    assign take     = if_valid & ~stall & (jump | (beqz & rs1_zero) | (bnez & ~rs1_zero));
    assign redirect = take;

    always_comb begin
        target_raw = if_pc4 + {{16{imm16[15]}}, imm16};
        if (jump_reg) begin
            target_raw = reg_target;
        end else if (jump) begin
            target_raw = if_pc4 + {{6{value[25]}}, value};
        end
        target = {target_raw[31:2], 2'b00};
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pend_pc_next    = pend_pc;
        skid_instr_next = skid_instr;
        skid_pc4_next   = skid_pc4;
        if_instr_next   = if_instr;
        if_pc4_next     = if_pc4;
        if_valid_next   = if_valid;
        case (state)
            FETCH: begin
                if (take) begin
                    if_instr_next = NOP_INSTR;
                    if_pc4_next   = 32'd0;
                    if_valid_next = 1'b0;
                    if (ack) begin
                        pc_next = target;
                    end else begin
                        // Keep the old address on the bus until the squashed ack returns.
                        pend_pc_next = target;
                        state_next   = DISCARD;
                    end
                end else if (ack) begin
                    pc_next = pc_plus4;
                    if (stall) begin
                        skid_instr_next = imem_rdata;
                        skid_pc4_next   = pc_plus4;
                        state_next      = HOLD;
                    end else begin
                        if_instr_next = imem_rdata;
                        if_pc4_next   = pc_plus4;
                        if_valid_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_next = FETCH;
                    if (take) begin
                        if_instr_next = NOP_INSTR;
                        if_pc4_next   = 32'd0;
                        if_valid_next = 1'b0;
                        pc_next       = target;
                    end else begin
                        if_instr_next = skid_instr;
                        if_pc4_next   = skid_pc4;
                        if_valid_next = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (ack) begin
                    pc_next    = pend_pc;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pend_pc    <= RESET_PC;
            skid_instr <= NOP_INSTR;
            skid_pc4   <= 32'd0;
            if_instr   <= NOP_INSTR;
            if_pc4     <= 32'd0;
            if_valid   <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pend_pc    <= pend_pc_next;
            skid_instr <= skid_instr_next;
            skid_pc4   <= skid_pc4_next;
            if_instr   <= if_instr_next;
            if_pc4     <= if_pc4_next;
            if_valid   <= if_valid_next;
        end
    end

endmodule

`default_nettype wire
